code_rdy_handshake_ctrl: RTL

CODE_RDY_HANDSHAKE_CTRL -- requirements
Module: code_rdy_handshake_ctrl

---
 rtl/code_rdy_handshake_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/code_rdy_handshake_ctrl.sv
// Avalon-MM slave that captures a code word from a producer and handshakes it to a host.
// Optional host-ack timeout is compiled in with the CODE_RDY_TIMEOUT_EN macro.
module code_rdy_handshake_ctrl #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    input  logic              code_valid,
    input  logic [DATA_W-1:0] code_data,
    output logic              code_ack
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPending = 2'd1,
        StDrain   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              overrun_q, overrun_d;
    logic              irq_mask_q;
    logic              code_ack_q, code_ack_d;
    logic              valid_q;
    logic              armed_q;
    logic [31:0]       readdata_q;
    logic [31:0]       rd_mux;
    logic              timeout_q;
    logic              timeout_hit;

    logic wr_en, rd_en, ack_wr, clr_wr, mask_wr, rise, pending;

    assign wr_en   = chipselect & write;
    assign rd_en   = chipselect & read;
    assign ack_wr  = wr_en & (address == 2'd3) & writedata[0];
    assign clr_wr  = wr_en & (address == 2'd3) & writedata[1];
    assign mask_wr = wr_en & (address == 2'd2);
    // armed_q blocks a capture when code_valid is already high as reset releases
    assign rise    = code_valid & ~valid_q & armed_q;
    assign pending = (state_q == StPending);

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        overrun_d  = overrun_q;
        code_ack_d = 1'b0;
        if (clr_wr) begin
            overrun_d = 1'b0;
        end
        case (state_q)
            StIdle: begin
                if (rise) begin
                    data_d  = code_data;
                    state_d = StPending;
                end
            end
            StPending: begin
                if (rise) begin
                    overrun_d = 1'b1;
                end
                if (ack_wr) begin
                    code_ack_d = 1'b1;
                    state_d    = StDrain;
                end else if (timeout_hit) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!code_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        case (address)
            2'd0: rd_mux = 32'(data_q);
            2'd1: rd_mux = {26'd0, state_q, 1'b0, timeout_q, overrun_q, pending};
            2'd2: rd_mux = {31'd0, irq_mask_q};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            data_q     <= '0;
            overrun_q  <= 1'b0;
            irq_mask_q <= 1'b0;
            code_ack_q <= 1'b0;
            valid_q    <= 1'b0;
            armed_q    <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            overrun_q  <= overrun_d;
            code_ack_q <= code_ack_d;
            valid_q    <= code_valid;
            if (!code_valid) begin
                armed_q <= 1'b1;
            end
            if (mask_wr) begin
                irq_mask_q <= writedata[0];
            end
            if (rd_en) begin
                readdata_q <= rd_mux;
            end
        end
    end

`ifdef CODE_RDY_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;

    assign timeout_hit = pending & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    // Counter idles at zero outside PENDING, so it restarts on every entry
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= pending ? cnt_q + CntW'(1) : '0;
            if (timeout_hit && !ack_wr) begin
                timeout_q <= 1'b1;
            end else if (clr_wr) begin
                timeout_q <= 1'b0;
            end
        end
    end
`else
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign timeout_hit        = 1'b0;
    assign timeout_q          = 1'b0;
`endif

    logic unused_wdata;
    assign unused_wdata = ^writedata[31:2];

    assign readdata = readdata_q;
    assign code_ack = code_ack_q;
    assign irq      = pending & irq_mask_q;

endmodule
